// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: memory read port, instruction delivery port
// and redirect request, as seen from the fetch unit (master) and its
// environment (slave).
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, pc_out,
    input  mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, pc_out,
    output mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word reads, buffers returned
// instructions with their addresses in a small FIFO, and restarts at a new
// target on redirect, discarding any response still in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           start_up_n,
  instr_fetch_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned XW = CW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          run;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          valid;
  logic          pop;
  logic          push;
  logic          room;
  logic          req;

  assign valid = (count != '0);
  assign pop   = valid & bus.instr_ready;
  assign push  = (state == WAIT) & bus.mem_rvalid;

  // At least one free slot once this cycle's pop and push are accounted for:
  // DEPTH - count + pop - push >= 1, rearranged to avoid an unsigned underflow.
  assign room = (XW'(count) + XW'(push)) < (XW'(DEPTH) + XW'(pop));

  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instruction = valid ? ins_mem[rd_ptr] : '0;
  assign bus.pc_out      = valid ? pc_mem[rd_ptr]  : '0;
  assign bus.mem_req     = req;

  // FSM state register
  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; redirect outranks a new request and turns an unanswered
  // request into one whose response is dropped
  always_comb begin
    state_nxt = state;
    if (bus.redirect) begin
      case (state)
        WAIT:    state_nxt = bus.mem_rvalid ? IDLE : FLUSH;
        FLUSH:   if (bus.mem_rvalid) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end else if (req) begin
      state_nxt = WAIT;
    end else if ((state != IDLE) && bus.mem_rvalid) begin
      state_nxt = IDLE;
    end
  end

  // FSM output: request whenever idle or the outstanding read completes now
  always_comb begin
    req = 1'b0;
    if (run && !bus.redirect && room) begin
      req = (state == IDLE) || ((state == WAIT) && bus.mem_rvalid);
    end
  end

  // Fetch address, request address, run flag and FIFO bookkeeping
  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run <= 1'b1;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc & ~32'h3;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are only visible through a nonzero count
  always_ff @(posedge clk) begin
    if (push && !bus.redirect) begin
      pc_mem[wr_ptr]  <= req_pc;
      ins_mem[wr_ptr] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a fixed-latency memory responder plus a
// transaction-level model of the expected instruction stream and of when a
// request is permitted. Directed steps first, then randomized traffic.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned due;
    int          kind;   // 0 keep, 1 dropped by redirect, 2 stale across reset
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic start_up_n;

  instr_fetch_if fif ();

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .start_up_n (start_up_n),
    .bus        (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int unsigned cyc;
  int unsigned lat;
  int unsigned req_cnt;
  int unsigned pop_cnt;

  logic        rst_drv;
  logic        rdy;
  logic        redir;
  logic [31:0] rpc;
  logic        run_m;
  logic [31:0] next_addr;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_ins;

  pend_t pend_q[$];
  ent_t  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, check, update model.
  task automatic cycle();
    logic  resp;
    logic  pop_m;
    logic  push_m;
    logic  exp_req;
    logic  blocked;
    int    active;
    int    size_after;
    pend_t r;
    pend_t t;
    ent_t  e;

    start_up_n      = rst_drv;
    fif.redirect    = redir;
    fif.redirect_pc = rpc;
    fif.instr_ready = rdy;
    resp = (pend_q.size() != 0) && (pend_q[0].due == cyc);
    fif.mem_rvalid = resp;
    fif.mem_rdata  = resp ? pend_q[0].data : $urandom;

    @(negedge clk);
    obs_req   = fif.mem_req;
    obs_addr  = fif.mem_addr;
    obs_valid = fif.instr_valid;
    obs_pc    = fif.pc_out;
    obs_ins   = fif.instruction;

    if (!rst_drv) begin
      chk("rst_mem_req", obs_req, 0);
      chk("rst_mem_addr", obs_addr, RESET_PC);
      chk("rst_valid", obs_valid, 0);
      chk("rst_instruction", obs_ins, 0);
      chk("rst_pc_out", obs_pc, 0);
      if (resp) void'(pend_q.pop_front());
      foreach (pend_q[i]) begin
        t = pend_q[i];
        t.kind = 2;
        pend_q[i] = t;
      end
      exp_q.delete();
      next_addr = RESET_PC;
    end else begin
      chk("instr_valid", obs_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("pc_out", obs_pc, exp_q[0].pc);
        chk("instruction", obs_ins, exp_q[0].data);
      end
      pop_m  = rdy && (exp_q.size() != 0);
      push_m = resp && (pend_q[0].kind == 0) && !redir;
      size_after = exp_q.size() - int'(pop_m) + int'(push_m);
      active  = 0;
      blocked = 1'b0;
      foreach (pend_q[i]) begin
        if (pend_q[i].kind != 2) begin
          if (resp && (i == 0)) begin
            if (pend_q[i].kind == 1) blocked = 1'b1;
          end else begin
            active++;
          end
        end
      end
      exp_req = run_m && !redir && (size_after < DEPTH) && (active == 0) && !blocked;
      chk("mem_req", obs_req, exp_req);
      if (obs_req) chk("mem_addr", obs_addr, next_addr);

      if (resp) r = pend_q.pop_front();
      if (redir) begin
        exp_q.delete();
        foreach (pend_q[i]) begin
          if (pend_q[i].kind == 0) begin
            t = pend_q[i];
            t.kind = 1;
            pend_q[i] = t;
          end
        end
        next_addr = {rpc[31:2], 2'b00};
      end else begin
        if (pop_m) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
        if (push_m) begin
          e.pc   = r.addr;
          e.data = r.data;
          exp_q.push_back(e);
        end
      end
      if (obs_req) begin
        t.addr = next_addr;
        t.data = $urandom;
        t.due  = cyc + lat;
        t.kind = 0;
        pend_q.push_back(t);
        next_addr = next_addr + 32'd4;
        req_cnt++;
      end
    end
    run_m = rst_drv;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_req(input int unsigned bound);
    int unsigned n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_req && (n < bound));
    chk("req_seen", obs_req, 1);
  endtask

  task automatic run_until_valid(input int unsigned bound);
    int unsigned n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_valid && (n < bound));
    chk("valid_seen", obs_valid, 1);
  endtask

  // Stall the consumer until nothing is in flight, then change memory latency.
  task automatic set_latency(input int unsigned l);
    int unsigned n;
    rdy   = 1'b0;
    redir = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (((pend_q.size() != 0) || (exp_q.size() < DEPTH)) && (n < 100));
    chk("drained", (pend_q.size() == 0), 1);
    lat = l;
  endtask

  initial begin
    int unsigned n;
    checks = 0; errors = 0; cyc = 0; lat = 1; req_cnt = 0; pop_cnt = 0;
    rst_drv = 1'b0; rdy = 1'b0; redir = 1'b0; rpc = '0; run_m = 1'b0;
    next_addr = RESET_PC;
    start_up_n = 1'b0;
    fif.redirect = 1'b0; fif.redirect_pc = '0; fif.instr_ready = 1'b0;
    fif.mem_rvalid = 1'b0; fif.mem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset values, then first request in the second cycle after release
    run(3);
    rst_drv = 1'b1;
    cycle();
    chk("release_no_req", obs_req, 0);
    cycle();
    chk("first_req", obs_req, 1);
    chk("first_addr", obs_addr, 32'h0);

    // Consumer stalled: buffer fills with 0x0 and 0x4, fetch stops
    run(8);
    chk("hold_valid", obs_valid, 1);
    chk("hold_pc", obs_pc, 32'h0);
    chk("hold_req", obs_req, 0);
    run(2);
    chk("hold_pc_stable", obs_pc, 32'h0);
    rdy = 1'b1;
    run_until_req(5);
    chk("resume_addr", obs_addr, 32'h8);

    // Sustained one instruction per cycle with 1-cycle memory
    run(5);
    req_cnt = 0;
    pop_cnt = 0;
    run(10);
    chk("tput_req", req_cnt, 10);
    chk("tput_pop", pop_cnt, 10);

    // 3-cycle memory: redirect one cycle after the request to 0x8
    set_latency(3);
    rdy = 1'b1; redir = 1'b1; rpc = 32'h0;
    cycle();
    redir = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(obs_req && (obs_addr == 32'h8)) && (n < 60));
    chk("req_0x8_seen", (obs_req && (obs_addr == 32'h8)), 1);
    redir = 1'b1; rpc = 32'h40;
    cycle();
    redir = 1'b0;
    run_until_req(20);
    chk("redir_addr", obs_addr, 32'h40);
    run_until_valid(20);
    chk("redir_pc", obs_pc, 32'h40);

    // Redirect coincident with a response and a pop
    redir = 1'b1; rpc = 32'h100;
    cycle();
    redir = 1'b0; rdy = 1'b0;
    n = 0;
    while (!((exp_q.size() >= 1) && (pend_q.size() != 0) && (pend_q[0].due == cyc)
             && (pend_q[0].kind == 0)) && (n < 60)) begin
      cycle();
      n++;
    end
    chk("coincide_setup", (n < 60), 1);
    rdy = 1'b1; redir = 1'b1; rpc = 32'h40;
    cycle();
    chk("coincide_pop", obs_valid, 1);
    redir = 1'b0;
    cycle();
    chk("coincide_valid", obs_valid, 0);
    chk("coincide_req", obs_req, 1);
    chk("coincide_addr", obs_addr, 32'h40);

    // Address wrap and target alignment
    redir = 1'b1; rpc = 32'hFFFF_FFFC;
    cycle();
    redir = 1'b0;
    run_until_req(20);
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    run_until_req(20);
    chk("wrap_addr1", obs_addr, 32'h0);
    redir = 1'b1; rpc = 32'h43;
    cycle();
    redir = 1'b0;
    run_until_req(20);
    chk("align_addr", obs_addr, 32'h40);

    // Reset with a request outstanding; late response must be ignored
    run_until_req(20);
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    run_until_valid(40);
    chk("post_reset_pc", obs_pc, RESET_PC);

    // Randomized traffic at each latency
    for (int unsigned seg = 1; seg <= 3; seg++) begin
      set_latency(seg);
      for (int unsigned i = 0; i < 150; i++) begin
        rdy   = ($urandom_range(0, 3) != 0);
        redir = ($urandom_range(0, 15) == 0);
        rpc   = $urandom;
        cycle();
      end
      redir = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: fetch address loaded at reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 start_up_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  instruction memory read request, one cycle per request.
REQ-006 mem_addr  output  32  word-aligned read address, valid when mem_req=1.
REQ-007 mem_rvalid  input  1  read data valid; exactly one pulse per request, at least 1 cycle after mem_req.
REQ-008 mem_rdata  input  32  read data, valid when mem_rvalid=1.
REQ-009 instr_valid  output  1  buffer head holds a valid instruction.
REQ-010 instruction  output  32  buffer head instruction word.
REQ-011 pc_out  output  32  address of the buffer head instruction.
REQ-012 instr_ready  input  1  processor consumes head when instr_valid=1 and instr_ready=1.
REQ-013 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-014 redirect_pc  input  32  redirect target address.

Function
REQ-015 The block SHALL hold registered state: fetch_pc, req_pc, run flag, FSM state, DEPTH-entry FIFO of {pc, instruction}, and the FIFO count.
REQ-016 FSM states SHALL be IDLE (no request outstanding), WAIT (request outstanding, response to be kept) and FLUSH (request outstanding, response to be dropped).
REQ-017 The run flag SHALL clear on reset and set at the first rising edge with start_up_n=1; mem_req SHALL be 0 while run=0.
REQ-018 Free slots SHALL equal DEPTH - count + pop - push, where pop = instr_valid & instr_ready and push = WAIT & mem_rvalid.
REQ-019 mem_req SHALL be combinational, equal to run & !redirect & (free slots >= 1) & (IDLE, or WAIT with mem_rvalid=1).
REQ-020 On mem_req: mem_addr = fetch_pc; req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 modulo 2^32; state <= WAIT.
REQ-021 In WAIT with mem_rvalid: push {req_pc, mem_rdata}; state <= IDLE unless a new request is issued in the same cycle, in which case state stays WAIT.
REQ-022 In FLUSH with mem_rvalid: no push; state <= IDLE; no request in that cycle.
REQ-023 In IDLE, mem_rvalid SHALL be ignored.
REQ-024 With a 1-cycle memory and instr_ready held at 1, sustained throughput SHALL be one instruction per cycle.
REQ-025 instr_valid = (count != 0); instruction and pc_out SHALL present the head entry and hold it stable while instr_ready=0.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and preserve order; count SHALL never exceed DEPTH or go below 0.
REQ-027 redirect SHALL have priority over every other event in the same cycle: FIFO cleared (count <= 0, any pop ignored); fetch_pc <= {redirect_pc[31:2], 2'b00}; no mem_req.
REQ-028 On redirect: WAIT without mem_rvalid -> FLUSH; WAIT with mem_rvalid -> IDLE and that data is dropped; FLUSH with mem_rvalid -> IDLE; otherwise the state is unchanged.
REQ-029 The first request after a redirect SHALL occur in the next cycle in which the REQ-019 conditions hold, with mem_addr equal to the aligned target.

Reset
REQ-030 While start_up_n=0: fetch_pc = RESET_PC; req_pc = 0; count = 0; state = IDLE; run = 0; mem_req = 0; mem_addr = RESET_PC; instr_valid = 0; instruction = 0; pc_out = 0.
REQ-031 Reset asserted mid-operation SHALL abandon any outstanding request; a response arriving after release SHALL be ignored (IDLE).

Verification
REQ-032 Reset, RESET_PC=0 -> all outputs at REQ-030 values; first mem_req in the second cycle after release, with mem_addr=0x00000000.
REQ-033 1-cycle memory, instr_ready=1 -> mem_addr 0x0, 0x4, 0x8 on consecutive cycles; pc_out 0x0, 0x4, 0x8 on consecutive cycles, instruction matching mem_rdata.
REQ-034 instr_ready=0, DEPTH=2 -> buffer holds pc 0x0 and 0x4; mem_req=0; pc_out=0x0 stable; raising instr_ready resumes fetch at 0x8.
REQ-035 3-cycle memory, redirect (redirect_pc=0x40) one cycle after the request to 0x8 -> the 0x8 data is never presented; next mem_addr=0x40 after the drop; next pc_out=0x40.
REQ-036 redirect coincident with mem_rvalid and with a pop -> response dropped; count=0; state IDLE; next mem_addr=0x40.
REQ-037 redirect_pc=0xFFFFFFFC -> mem_addr 0xFFFFFFFC then 0x00000000; redirect_pc=0x43 -> mem_addr 0x40.
